encode_packet: RTL and testbench

- Transmit-side USB packet encoder: builds handshake and DATAx packets for the host-bound direction and emits them byte-serially on an AXI-stream towards the ULPI transmitter.
- Transaction logic (control/bulk EP cores) requests a handshake or a data packet; payload bytes arrive on a separate AXI-stream.
- Adds the PID byte (PID plus inverted-PID check nibble) and, for data packets, the trailing CRC16.

---
 rtl/encode_packet.sv | 172 +++++++++++++++++
 tb/tb_encode_packet.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encode_packet.sv
// USB transmit packet encoder: PID byte, payload and CRC16 as one byte stream.
// Handshake and DATAx packets leave through a single output register stage.
module encode_packet #(
    parameter int MAX_PACKET_SIZE = 512
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_trn_send_hsk_i,
    input  logic [1:0] tx_trn_hsk_type_i,
    input  logic       tx_trn_send_data_i,
    input  logic [1:0] tx_trn_data_type_i,
    input  logic       tx_trn_zlp_i,
    input  logic       s_tvalid_i,
    output logic       s_tready_o,
    input  logic       s_tlast_i,
    input  logic [7:0] s_tdata_i,
    output logic       tx_tvalid_o,
    input  logic       tx_tready_i,
    output logic       tx_tlast_o,
    output logic [7:0] tx_tdata_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       overflow_o
);
    localparam int CW = $clog2(MAX_PACKET_SIZE + 1);

    typedef enum logic [2:0] {
        IDLE, HSK, PID, DATA, CRC_LO, CRC_HI, DRAIN
    } state_t;

    state_t        state;
    logic [15:0]   crc;
    logic [CW-1:0] count;
    logic          zlp;
    logic          lo_loaded;
    logic          ovf;

    logic          xfer;
    logic          free;
    logic          load_ok;
    logic          take;
    logic          ovf_hit;
    logic [15:0]   crc_next;
    logic [3:0]    hsk_pid;
    logic [3:0]    data_pid;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c_in,
                                               input logic [7:0]  d);
        logic [15:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++)
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        return c;
    endfunction

    assign xfer     = tx_tvalid_o && tx_tready_i;
    assign free     = !tx_tvalid_o || tx_tready_i;
    assign hsk_pid  = {tx_trn_hsk_type_i, 2'b10};
    assign data_pid = {tx_trn_data_type_i, 2'b11};

    // Payload may slip in behind the PID so the stream has no bubble.
    assign load_ok  = (state == DATA && free) ||
                      (state == PID && !zlp && tx_tready_i);
    assign take     = !reset && load_ok && s_tvalid_i;
    assign ovf_hit  = take && !s_tlast_i &&
                      count == CW'(MAX_PACKET_SIZE - 1);
    assign crc_next = crc16_byte(crc, s_tdata_i);

    assign s_tready_o = !reset && (load_ok || state == DRAIN);
    assign done_o     = !reset && xfer && tx_tlast_o;
    assign overflow_o = ovf_hit;
    assign busy_o     = (state != IDLE) ||
                        (!reset && (tx_trn_send_hsk_i || tx_trn_send_data_i));

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            tx_tvalid_o <= 1'b0;
            tx_tlast_o  <= 1'b0;
            tx_tdata_o  <= 8'h00;
            crc         <= 16'hFFFF;
            count       <= '0;
            zlp         <= 1'b0;
            lo_loaded   <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (tx_trn_send_hsk_i) begin
                        tx_tdata_o  <= {~hsk_pid, hsk_pid};
                        tx_tlast_o  <= 1'b1;
                        tx_tvalid_o <= 1'b1;
                        state       <= HSK;
                    end else if (tx_trn_send_data_i) begin
                        tx_tdata_o  <= {~data_pid, data_pid};
                        tx_tlast_o  <= 1'b0;
                        tx_tvalid_o <= 1'b1;
                        zlp         <= tx_trn_zlp_i;
                        state       <= PID;
                    end
                end
                HSK: begin
                    if (xfer) begin
                        tx_tvalid_o <= 1'b0;
                        tx_tlast_o  <= 1'b0;
                        state       <= IDLE;
                    end
                end
                PID: begin
                    if (xfer) begin
                        if (zlp) begin
                            tx_tdata_o <= ~crc[7:0];
                            lo_loaded  <= 1'b1;
                            state      <= CRC_LO;
                        end else begin
                            tx_tvalid_o <= 1'b0;
                            state       <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer)
                        tx_tvalid_o <= 1'b0;
                end
                CRC_LO: begin
                    // The last payload byte may still occupy the register.
                    if (!lo_loaded && free) begin
                        tx_tdata_o  <= ~crc[7:0];
                        tx_tlast_o  <= 1'b0;
                        tx_tvalid_o <= 1'b1;
                        lo_loaded   <= 1'b1;
                    end else if (lo_loaded && xfer) begin
                        tx_tdata_o <= ~crc[15:8];
                        tx_tlast_o <= 1'b1;
                        state      <= CRC_HI;
                    end
                end
                CRC_HI: begin
                    if (xfer) begin
                        tx_tvalid_o <= 1'b0;
                        tx_tlast_o  <= 1'b0;
                        crc         <= 16'hFFFF;
                        count       <= '0;
                        lo_loaded   <= 1'b0;
                        state       <= ovf ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (s_tvalid_i && s_tlast_i) begin
                        ovf   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (take) begin
                tx_tdata_o  <= s_tdata_i;
                tx_tlast_o  <= 1'b0;
                tx_tvalid_o <= 1'b1;
                crc         <= crc_next;
                count       <= count + CW'(1);
                if (s_tlast_i || ovf_hit) begin
                    lo_loaded <= 1'b0;
                    state     <= CRC_LO;
                end
                if (ovf_hit)
                    ovf <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_encode_packet.sv
// Scoreboard bench for encode_packet: a 512-byte and a 4-byte instance share
// stimulus, one selected at a time, checked against a packet-level model.
module tb_encode_packet;
    logic       clock = 1'b0;
    logic       reset;
    logic       req_hsk, req_data, req_zlp;
    logic [1:0] htype, dtype;
    logic       s_tvalid, s_tlast;
    logic [7:0] s_tdata;
    logic       tx_tready;
    logic       sel;

    logic       s_tready_a, tx_tvalid_a, tx_tlast_a, busy_a, done_a, ovf_a;
    logic       s_tready_b, tx_tvalid_b, tx_tlast_b, busy_b, done_b, ovf_b;
    logic [7:0] tx_tdata_a, tx_tdata_b;

    logic       s_tready, tx_tvalid, tx_tlast, busy, done, overflow;
    logic [7:0] tx_tdata;

    logic [8:0] exp_q[$];
    logic [8:0] pay_q[$];
    int         xfer_cyc[$];
    int         checks = 0, failures = 0;
    int         done_cnt = 0, ovf_cnt = 0, exp_done = 0, exp_ovf = 0;
    int         cyc = 0;
    bit         stall_en = 1'b0;
    bit         zlp_watch = 1'b0;

    always #5 clock = ~clock;

    encode_packet #(.MAX_PACKET_SIZE(512)) u_big (
        .clock(clock), .reset(reset),
        .tx_trn_send_hsk_i(req_hsk && !sel), .tx_trn_hsk_type_i(htype),
        .tx_trn_send_data_i(req_data && !sel), .tx_trn_data_type_i(dtype),
        .tx_trn_zlp_i(req_zlp),
        .s_tvalid_i(s_tvalid && !sel), .s_tready_o(s_tready_a),
        .s_tlast_i(s_tlast), .s_tdata_i(s_tdata),
        .tx_tvalid_o(tx_tvalid_a), .tx_tready_i(tx_tready),
        .tx_tlast_o(tx_tlast_a), .tx_tdata_o(tx_tdata_a),
        .busy_o(busy_a), .done_o(done_a), .overflow_o(ovf_a)
    );

    encode_packet #(.MAX_PACKET_SIZE(4)) u_small (
        .clock(clock), .reset(reset),
        .tx_trn_send_hsk_i(req_hsk && sel), .tx_trn_hsk_type_i(htype),
        .tx_trn_send_data_i(req_data && sel), .tx_trn_data_type_i(dtype),
        .tx_trn_zlp_i(req_zlp),
        .s_tvalid_i(s_tvalid && sel), .s_tready_o(s_tready_b),
        .s_tlast_i(s_tlast), .s_tdata_i(s_tdata),
        .tx_tvalid_o(tx_tvalid_b), .tx_tready_i(tx_tready),
        .tx_tlast_o(tx_tlast_b), .tx_tdata_o(tx_tdata_b),
        .busy_o(busy_b), .done_o(done_b), .overflow_o(ovf_b)
    );

    assign s_tready  = sel ? s_tready_b  : s_tready_a;
    assign tx_tvalid = sel ? tx_tvalid_b : tx_tvalid_a;
    assign tx_tlast  = sel ? tx_tlast_b  : tx_tlast_a;
    assign tx_tdata  = sel ? tx_tdata_b  : tx_tdata_a;
    assign busy      = sel ? busy_b      : busy_a;
    assign done      = sel ? done_b      : done_a;
    assign overflow  = sel ? ovf_b       : ovf_a;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Packet values straight from the USB PID tables.
    function automatic logic [7:0] hsk_pid(input logic [1:0] t);
        case (t)
            2'b00:   return 8'hD2;
            2'b10:   return 8'h5A;
            2'b11:   return 8'h1E;
            default: return 8'h96;
        endcase
    endfunction

    function automatic logic [7:0] data_pid(input logic [1:0] t);
        case (t)
            2'b00:   return 8'hC3;
            2'b10:   return 8'h4B;
            2'b01:   return 8'h87;
            default: return 8'h0F;
        endcase
    endfunction

    function automatic logic [15:0] crc_usb(input logic [7:0] q[$]);
        logic [15:0] c;
        bit          fb;
        c = 16'hFFFF;
        foreach (q[k])
            for (int i = 0; i < 8; i++) begin
                fb = c[0] ^ q[k][i];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        return ~c;
    endfunction

    task automatic expect_data(input logic [1:0] t, input logic [7:0] pl[$],
                               input bit z, input int maxp);
        logic [7:0]  sent[$];
        logic [15:0] c;
        exp_q.push_back({1'b0, data_pid(t)});
        if (!z) begin
            foreach (pl[i]) begin
                pay_q.push_back({i == pl.size() - 1, pl[i]});
                if (i < maxp) begin
                    sent.push_back(pl[i]);
                    exp_q.push_back({1'b0, pl[i]});
                end
            end
            if (pl.size() > maxp) exp_ovf++;
        end
        c = crc_usb(sent);
        exp_q.push_back({1'b0, c[7:0]});
        exp_q.push_back({1'b1, c[15:8]});
        exp_done++;
    endtask

    task automatic request(input bit h, input bit d, input logic [1:0] ht,
                           input logic [1:0] dt, input bit z);
        @(posedge clock); #1;
        req_hsk = h; req_data = d; htype = ht; dtype = dt; req_zlp = z;
        @(posedge clock); #1;
        req_hsk = 1'b0; req_data = 1'b0; req_zlp = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check({name, "_timeout"}, 32'(n < 3000), 32'd1);
        check({name, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
        check({name, "_ovf_cnt"}, 32'(ovf_cnt), 32'(exp_ovf));
    endtask

    task automatic check_zero(input string name);
        check(name, 32'({tx_tvalid, tx_tlast, tx_tdata, s_tready,
                         busy, done, overflow}), 32'd0);
    endtask

    // Payload source: presents the head of pay_q, pops it once accepted.
    initial begin
        bit fire;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00;
        forever begin
            @(negedge clock);
            fire = s_tvalid && s_tready;
            @(posedge clock); #1;
            if (fire && pay_q.size() > 0) void'(pay_q.pop_front());
            if (pay_q.size() > 0) begin
                s_tvalid = 1'b1;
                {s_tlast, s_tdata} = pay_q[0];
            end else begin
                s_tvalid = 1'b0;
            end
        end
    end

    initial begin
        tx_tready = 1'b1;
        forever begin
            @(posedge clock); #1;
            tx_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each transfer, checks hold while stalled.
    initial begin
        bit         stalled;
        logic [8:0] held;
        logic [8:0] got;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled)
                    check("hold", 32'({tx_tvalid, tx_tlast, tx_tdata}),
                          32'({1'b1, held}));
                if (zlp_watch)
                    check("zlp_tready", 32'(s_tready), 32'd0);
                if (tx_tvalid && tx_tready) begin
                    got = {tx_tlast, tx_tdata};
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte: got %0h expected none",
                                 got);
                    end else begin
                        check("byte", 32'(got), 32'(exp_q.pop_front()));
                    end
                    xfer_cyc.push_back(cyc);
                end
                stalled = tx_tvalid && !tx_tready;
                held = {tx_tlast, tx_tdata};
                if (done) done_cnt++;
                if (overflow) ovf_cnt++;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pl[$];
        logic [7:0] none[$];
        int         saved;
        reset = 1'b1;
        req_hsk = 1'b0; req_data = 1'b0; req_zlp = 1'b0;
        htype = 2'b00; dtype = 2'b00; sel = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_zero("reset_big");
        sel = 1'b1; #1;
        check_zero("reset_small");
        sel = 1'b0;

        // Handshake NAK with exact timing.
        @(posedge clock); #1;
        req_hsk = 1'b1; htype = 2'b10;
        exp_q.push_back({1'b1, 8'h5A});
        exp_done++;
        @(negedge clock);
        check("hsk_accept", 32'({busy, tx_tvalid}), 32'b10);
        @(posedge clock); #1;
        req_hsk = 1'b0;
        @(negedge clock);
        check("hsk_byte", 32'({tx_tvalid, tx_tlast, done, busy, tx_tdata}),
              32'({4'b1111, 8'h5A}));
        @(negedge clock);
        check("hsk_idle", 32'({busy, tx_tvalid}), 32'b00);
        wait_done("hsk");

        // DATA1 zero-length: payload stream left alone.
        pay_q.push_back({1'b1, 8'hAA});
        zlp_watch = 1'b1;
        exp_q.push_back({1'b0, 8'h4B});
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b1, 8'h00});
        exp_done++;
        request(1'b0, 1'b1, 2'b00, 2'b10, 1'b1);
        wait_done("zlp");
        zlp_watch = 1'b0;
        check("zlp_untouched", 32'(pay_q.size()), 32'd1);
        @(negedge clock);
        pay_q.delete();
        repeat (2) @(negedge clock);

        // "123456789" back to back, then with random stalls.
        for (int pass = 0; pass < 2; pass++) begin
            stall_en = (pass == 1);
            xfer_cyc.delete();
            for (int i = 0; i < 9; i++)
                pay_q.push_back({i == 8, 8'h31 + 8'(i)});
            exp_q.push_back({1'b0, 8'hC3});
            for (int i = 0; i < 9; i++)
                exp_q.push_back({1'b0, 8'h31 + 8'(i)});
            exp_q.push_back({1'b0, 8'hC8});
            exp_q.push_back({1'b1, 8'hB4});
            exp_done++;
            request(1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
            wait_done(pass == 0 ? "check9" : "check9_stall");
            check("check9_count", 32'(xfer_cyc.size()), 32'd12);
            if (pass == 0 && xfer_cyc.size() == 12)
                check("check9_span", 32'(xfer_cyc[11] - xfer_cyc[0]), 32'd11);
        end
        stall_en = 1'b0;

        // Small instance: exact fit, then 6 bytes overflowing MAX=4.
        sel = 1'b1;
        for (int len = 4; len <= 6; len += 2) begin
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            expect_data(2'b01, pl, 1'b0, 4);
            request(1'b0, 1'b1, 2'b00, 2'b01, 1'b0);
            wait_done(len == 4 ? "fit4" : "ovf6");
            check("drained", 32'(pay_q.size()), 32'd0);
        end
        sel = 1'b0;

        // Simultaneous requests: only NYET goes out.
        exp_q.push_back({1'b1, 8'h96});
        exp_done++;
        request(1'b1, 1'b1, 2'b01, 2'b00, 1'b0);
        wait_done("hsk_prio");

        // Reset mid-payload aborts the packet.
        saved = exp_done;
        pl.delete();
        for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
        expect_data(2'b10, pl, 1'b0, 512);
        request(1'b0, 1'b1, 2'b00, 2'b10, 1'b0);
        repeat (4) @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("reset_no_take", 32'(s_tready), 32'd0);
        exp_q.delete();
        pay_q.delete();
        exp_done = saved;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_zero("reset_mid");
        exp_q.push_back({1'b1, 8'h1E});
        exp_done++;
        request(1'b1, 1'b0, 2'b11, 2'b00, 1'b0);
        wait_done("after_reset");

        // Randomised packets on both instances.
        for (int n = 0; n < 12; n++) begin
            int len;
            logic [1:0] t;
            sel = 1'($urandom_range(0, 1));
            stall_en = 1'($urandom_range(0, 1));
            t = 2'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                exp_q.push_back({1'b1, hsk_pid(t)});
                exp_done++;
                request(1'b1, 1'b0, t, 2'b00, 1'b0);
            end else begin
                len = $urandom_range(0, 10);
                pl.delete();
                for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
                expect_data(t, len == 0 ? none : pl, len == 0, sel ? 4 : 512);
                request(1'b0, 1'b1, 2'b00, t, len == 0);
            end
            wait_done("random");
            check("random_drained", 32'(pay_q.size()), 32'd0);
        end
        stall_en = 1'b0;
        sel = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
